// File: rtl/jx2_mem_line_responder.sv
//------------------------------------------------------------------------------
// jx2_mem_line_responder
//
// Responder end of the 128-bit line memory bus. Accepts line read, write and
// swap requests, services them from an internal line-wide block RAM after a
// fixed latency, and reports status on memOK. Used as the backing memory
// below the L1 arbiter for simulation and FPGA bring-up.
//
// Parameters
//   ADDR_BITS  line-index bits; the RAM holds 2^ADDR_BITS lines of 128 bits
//   LATENCY    cycles from request sample to OK (2..15)
//   BASE       window base; memAddr[31:4+ADDR_BITS] must match it
//
// Ports
//   clock       in   1    clock
//   reset       in   1    asynchronous active-high reset
//   memAddr     in   32   line address, index = memAddr[4+ADDR_BITS-1:4]
//   memOpm      in   5    [4]=write, [3]=read, 0 = no request
//   memDataIn   in   128  write line from the initiator
//   memDataOut  out  128  read line to the initiator
//   memOK       out  2    0=READY 1=OK 2=HOLD 3=FAULT
//------------------------------------------------------------------------------
module jx2_mem_line_responder #(
  parameter int          ADDR_BITS = 14,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE      = 32'h0100_0000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  memAddr,
  input  logic [4:0]   memOpm,
  input  logic [127:0] memDataIn,
  output logic [127:0] memDataOut,
  output logic [1:0]   memOK
);

  localparam int HI = 4 + ADDR_BITS;

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    FLT  = 2'd3
  } state_t;

  state_t                 stateReg;
  logic [3:0]             cntReg;
  logic [ADDR_BITS-1:0]   latIdx;
  logic [1:0]             latOpm;   // [1]=read, [0]=write
  logic [127:0]           latData;

  logic [127:0]           mem [2**ADDR_BITS];
  logic [127:0]           ramRdData;
  logic [ADDR_BITS-1:0]   reqIdx;
  logic [ADDR_BITS-1:0]   rdIdx;
  logic                   inWindow;
  logic                   commit;
  logic                   ramWe;

  // Low address bits and opm[2:0] carry no meaning for this responder.
  logic unusedBits;
  assign unusedBits = ^{memOpm[2:0], memAddr[3:0]};

  assign reqIdx   = memAddr[HI-1:4];
  assign inWindow = (memAddr[31:HI] == BASE[31:HI]);
  assign commit   = (stateReg == BUSY) && (cntReg == 4'd1);
  assign ramWe    = commit && latOpm[0];

  // The RAM is read every cycle so that its registered output already holds
  // the target line on the commit edge: while IDLE the live request index is
  // used (covers LATENCY=2, where commit follows the sample edge directly),
  // afterwards the latched index. Nothing writes the RAM before commit, so
  // the value read is the pre-commit contents, giving read-before-write for
  // swaps.
  assign rdIdx = (stateReg == IDLE) ? reqIdx : latIdx;

  always_ff @(posedge clock) begin
    if (ramWe) begin
      mem[latIdx] <= latData;
    end
    ramRdData <= mem[rdIdx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      memOK      <= OK_READY;
      memDataOut <= '0;
      cntReg     <= '0;
      latIdx     <= '0;
      latOpm     <= '0;
      latData    <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (memOpm != 5'd0) begin
            if (memOpm[4:3] == 2'b00 || !inWindow) begin
              stateReg <= FLT;
              memOK    <= OK_FAULT;
            end else begin
              latIdx   <= reqIdx;
              latOpm   <= {memOpm[3], memOpm[4]};
              latData  <= memDataIn;
              cntReg   <= 4'(LATENCY - 1);
              stateReg <= BUSY;
              memOK    <= OK_HOLD;
            end
          end
        end
        BUSY: begin
          // Bus inputs are deliberately ignored here: the latched request wins.
          if (cntReg == 4'd1) begin
            stateReg   <= DONE;
            memOK      <= OK_OK;
            cntReg     <= '0;
            memDataOut <= latOpm[1] ? ramRdData : latData;
          end else begin
            cntReg <= cntReg - 4'd1;
          end
        end
        DONE, FLT: begin
          if (memOpm == 5'd0) begin
            stateReg <= IDLE;
            memOK    <= OK_READY;
          end
        end
        default: begin
          stateReg <= IDLE;
          memOK    <= OK_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jx2_mem_line_responder.sv
module tb_jx2_mem_line_responder;

  localparam int LAT = 4;

  logic         clock;
  logic         reset;
  logic [31:0]  memAddr;
  logic [4:0]   memOpm;
  logic [127:0] memDataIn;
  logic [127:0] memDataOut;
  logic [1:0]   memOK;

  int numChecks;
  int numErrors;

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] D1234 = 128'h1234;
  localparam logic [127:0] BEEF = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] ONES = {128{1'b1}};

  jx2_mem_line_responder #(
    .ADDR_BITS(14),
    .LATENCY  (LAT),
    .BASE     (32'h0100_0000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .memAddr   (memAddr),
    .memOpm    (memOpm),
    .memDataIn (memDataIn),
    .memDataOut(memDataOut),
    .memOK     (memOK)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full request: HOLD for LAT-1 cycles, OK with data, stays OK while opm held,
  // READY one cycle after opm drops.
  task automatic doReq(input string tag, input logic [31:0] addr, input logic [4:0] opm,
                       input logic [127:0] wdata, input logic [127:0] expData);
    memAddr   = addr;
    memOpm    = opm;
    memDataIn = wdata;
    for (int i = 1; i < LAT; i++) begin
      tick();
      check({tag, " hold"}, 128'(memOK), 128'(2'd2));
    end
    tick();
    check({tag, " ok"}, 128'(memOK), 128'(2'd1));
    check({tag, " data"}, memDataOut, expData);
    memDataIn = ~wdata;
    tick();
    check({tag, " ok held"}, 128'(memOK), 128'(2'd1));
    check({tag, " data held"}, memDataOut, expData);
    memOpm = 5'd0;
    tick();
    check({tag, " ready"}, 128'(memOK), 128'(2'd0));
  endtask

  initial begin
    numChecks = 0;
    numErrors = 0;
    reset     = 1'b1;
    memAddr   = 32'd0;
    memOpm    = 5'd0;
    memDataIn = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1. idle after reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset memOK", 128'(memOK), 128'(2'd0));
      check("reset data", memDataOut, 128'd0);
    end

    // 2. write then read back
    doReq("write20", 32'h0100_0020, 5'h10, A5, A5);
    doReq("read20", 32'h0100_0020, 5'h08, '0, A5);

    // 3. swap returns old line, read returns new
    doReq("swap20", 32'h0100_0020, 5'h18, D1234, A5);
    doReq("read20b", 32'h0100_0020, 5'h08, '0, D1234);

    // 4. out-of-window read faults until opm drops
    memAddr = 32'h0200_0000;
    memOpm  = 5'h08;
    tick();
    check("win fault", 128'(memOK), 128'(2'd3));
    tick();
    check("win fault held", 128'(memOK), 128'(2'd3));
    check("win data kept", memDataOut, D1234);
    memOpm = 5'd0;
    tick();
    check("win ready", 128'(memOK), 128'(2'd0));
    doReq("read20c", 32'h0100_0020, 5'h08, '0, D1234);

    // 5. opm without rd/wr bit faults
    memAddr = 32'h0100_0020;
    memOpm  = 5'h03;
    tick();
    check("opm fault", 128'(memOK), 128'(2'd3));
    memOpm = 5'd0;
    tick();
    check("opm ready", 128'(memOK), 128'(2'd0));

    // preload 0x40, then read 0x20 with inputs changing during BUSY
    doReq("write40", 32'h0100_0040, 5'h10, BEEF, BEEF);
    memAddr = 32'h0100_0020;
    memOpm  = 5'h08;
    tick();
    check("latch hold", 128'(memOK), 128'(2'd2));
    memAddr = 32'h0100_0040;
    memOpm  = 5'd0;
    tick();
    check("latch hold2", 128'(memOK), 128'(2'd2));
    tick();
    check("latch hold3", 128'(memOK), 128'(2'd2));
    tick();
    check("latch ok", 128'(memOK), 128'(2'd1));
    check("latch data", memDataOut, D1234);
    tick();
    check("latch ready", 128'(memOK), 128'(2'd0));

    // 6. reset two cycles into a write aborts it
    memAddr   = 32'h0100_0040;
    memOpm    = 5'h10;
    memDataIn = ONES;
    tick();
    tick();
    check("abort hold", 128'(memOK), 128'(2'd2));
    reset = 1'b1;
    #1;
    check("abort memOK", 128'(memOK), 128'(2'd0));
    check("abort data", memDataOut, 128'd0);
    memOpm = 5'd0;
    tick();
    reset = 1'b0;
    tick();
    check("post reset", 128'(memOK), 128'(2'd0));
    doReq("read40", 32'h0100_0040, 5'h08, '0, BEEF);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
